// File: rtl/ternary_word_sequencer.sv
// Serial ternary word unit: one shared min/max/consensus/any gate applied trit by trit,
// either element-wise across two words or as an ascending-order fold of one word.
module ternary_word_sequencer #(
  parameter int unsigned TRITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [2*TRITS-1:0] a,
  input  logic [2*TRITS-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*TRITS-1:0] result,
  output logic               err
);

  localparam int unsigned W  = 2 * TRITS;
  localparam int unsigned IW = $clog2(TRITS);
  localparam logic [IW-1:0] LAST = IW'(TRITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   index_q, index_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      acc_q, acc_d;
  logic            err_q, err_d;

  logic [1:0]      a_trit, b_trit, lhs, rhs, g;
  logic            bad, err_n;

  function automatic logic [1:0] gate(input logic [1:0] fop, input logic [1:0] x,
                                      input logic [1:0] y);
    logic [1:0] r;
    r = 2'd1;
    case (fop)
      2'b00:   r = (x < y) ? x : y;
      2'b01:   r = (x > y) ? x : y;
      2'b10:   r = (x == y) ? x : 2'd1;
      default: begin
        if (x == y)        r = x;
        else if (x == 2'd1) r = y;
        else if (y == 2'd1) r = x;
        else               r = 2'd1;
      end
    endcase
    return r;
  endfunction

  always_comb begin
    a_trit = a_q[{index_q, 1'b0} +: 2];
    b_trit = b_q[{index_q, 1'b0} +: 2];
    lhs    = op_q[2] ? acc_q  : a_trit;
    rhs    = op_q[2] ? a_trit : b_trit;
    g      = gate(op_q[1:0], lhs, rhs);
    bad    = (a_trit == 2'b11) || (!op_q[2] && (b_trit == 2'b11));
    err_n  = err_q | bad;
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          result_d = '0;
          acc_d    = a[1:0];
          // In reduce mode trit 0 seeds the accumulator, so its validity is judged here.
          err_d    = op[2] && (a[1:0] == 2'b11);
          index_d  = op[2] ? IW'(1) : '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        err_d   = err_n;
        index_d = index_q + IW'(1);
        if (op_q[2]) acc_d = g;
        else         result_d[{index_q, 1'b0} +: 2] = g;
        if (index_q == LAST) begin
          state_d = DONE;
          index_d = '0;
          if (op_q[2]) begin
            result_d      = '0;
            result_d[1:0] = g;
          end
          if (err_n) result_d = '0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign err       = err_q;

endmodule
